// File: rtl/uart_rx_os16.sv
// uart_rx_os16 - 16x oversampling UART receiver.
// Runs entirely on PCLK and advances only on s_tick enables.
// The rx line passes through a 2-FF synchroniser. The start bit is validated at mid-bit.
// Data bits are sampled LSB-first at the centre of each bit.
// Each frame is delivered with a one-cycle rx_done pulse and error flags.
// Optional feature: define UART_RX_PARITY_EN to receive and check a parity bit
// after the data bits. Without it, rx_parity_err is tied low.

module uart_rx_os16 #(
    parameter int DBITS      = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             s_tick,
    input  logic             rx,
    output logic [DBITS-1:0] rx_dout,
    output logic             rx_done,
    output logic             rx_frame_err,
    output logic             rx_parity_err,
    output logic             rx_busy
);

    // The tick counter must reach SB_TICK-1 in the stop state, so it may need more than 4 bits.
    localparam int TW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = $clog2(DBITS + 1);

    localparam logic [TW-1:0] LP_MID_TICK  = TW'(7);
    localparam logic [TW-1:0] LP_LAST_TICK = TW'(15);
    localparam logic [TW-1:0] LP_STOP_TICK = TW'(SB_TICK - 1);
    localparam logic [NW-1:0] LP_LAST_BIT  = NW'(DBITS - 1);
    localparam logic          LP_ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } rxState_t;

    rxState_t         r_state;
    logic             r_rxMeta;
    logic             r_rxSync;
    logic [TW-1:0]    r_tickCnt;
    logic [NW-1:0]    r_bitCnt;
    logic [DBITS-1:0] r_shift;
    logic [DBITS-1:0] r_dout;
    logic             r_done;
    logic             r_frameErr;
`ifdef UART_RX_PARITY_EN
    logic             r_parBit;
    logic             r_parityErr;
`endif

    // Two-flop synchroniser, preset to the idle-high line level so reset does not look like a start bit.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
        end
    end

    // Receive FSM. The IDLE and BREAK exits are evaluated every cycle; all other states move only on s_tick.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_tickCnt   <= '0;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_dout      <= '0;
            r_done      <= 1'b0;
            r_frameErr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parBit    <= 1'b0;
            r_parityErr <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parityErr <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (!r_rxSync) begin
                        r_state   <= START;
                        r_tickCnt <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (r_tickCnt == LP_MID_TICK) begin
                            if (!r_rxSync) begin
                                r_state   <= DATA;
                                r_tickCnt <= '0;
                                r_bitCnt  <= '0;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_tickCnt <= r_tickCnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (r_tickCnt == LP_LAST_TICK) begin
                            r_tickCnt <= '0;
                            r_shift   <= {r_rxSync, r_shift[DBITS-1:1]};
                            if (r_bitCnt == LP_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= PARITY;
`else
                                r_state <= STOP;
`endif
                            end else begin
                                r_bitCnt <= r_bitCnt + 1'b1;
                            end
                        end else begin
                            r_tickCnt <= r_tickCnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (r_tickCnt == LP_LAST_TICK) begin
                            r_parBit  <= r_rxSync;
                            r_tickCnt <= '0;
                            r_state   <= STOP;
                        end else begin
                            r_tickCnt <= r_tickCnt + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (s_tick) begin
                        if (r_tickCnt == LP_STOP_TICK) begin
                            r_dout     <= r_shift;
                            r_done     <= 1'b1;
                            r_frameErr <= !r_rxSync;
`ifdef UART_RX_PARITY_EN
                            r_parityErr <= ((^r_shift) ^ r_parBit) != LP_ODD;
`endif
                            r_tickCnt  <= '0;
                            r_state    <= r_rxSync ? IDLE : BREAK;
                        end else begin
                            r_tickCnt <= r_tickCnt + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (r_rxSync) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rx_dout      = r_dout;
    assign rx_done      = r_done;
    assign rx_frame_err = r_frameErr;
    assign rx_busy      = (r_state != IDLE) && (r_state != BREAK);

`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = r_parityErr;
`else
    // Without a parity bit the parity sense has nothing to act on, so the flag is held low.
    assign rx_parity_err = LP_ODD & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16 - self-checking bench for uart_rx_os16.
// The setup uses DBITS=8, SB_TICK=16, s_tick every 4 PCLK and a bit period of 64 PCLK.
// Expected results come from a frame-level model: each complete frame yields one byte,
// frame_err = !stop and parity_err = parity mismatch.

module tb_uart_rx_os16;

    localparam int   BITP    = 64;
    localparam logic PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int   FRAME_BITS = 11;
`else
    localparam int   FRAME_BITS = 10;
`endif

    logic       PCLK;
    logic       PRESETn;
    logic       s_tick;
    logic       rx;
    logic [7:0] rx_dout;
    logic       rx_done;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_busy;

    int compared;
    int mismatched;
    int cycle;
    int strayFlags;

    logic [7:0] obsData[$];
    logic       obsFerr[$];
    logic       obsPerr[$];
    logic       obsBusy[$];
    int         obsTime[$];

    logic [7:0] expData[$];
    logic       expFerr[$];
    logic       expPerr[$];
    logic [7:0] lastData;

    uart_rx_os16 #(
        .DBITS(8),
        .SB_TICK(16),
        .PARITY_ODD(0)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .s_tick(s_tick),
        .rx(rx),
        .rx_dout(rx_dout),
        .rx_done(rx_done),
        .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err),
        .rx_busy(rx_busy)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // The 16x tick fires on one cycle in every four and is driven away from the active edge.
    initial begin
        int k;
        k = 0;
        s_tick = 1'b0;
        forever begin
            @(negedge PCLK);
            k++;
            s_tick = (k % 4 == 0);
        end
    end

    // The monitor samples 1 ns after each rising edge and records every done pulse with its flags and time.
    initial begin
        logic prevDone;
        prevDone = 1'b0;
        cycle = 0;
        forever begin
            @(posedge PCLK);
            #1;
            cycle++;
            if (prevDone) obsBusy.push_back(rx_busy);
            if (rx_done) begin
                obsData.push_back(rx_dout);
                obsFerr.push_back(rx_frame_err);
                obsPerr.push_back(rx_parity_err);
                obsTime.push_back(cycle);
            end else if (rx_frame_err || rx_parity_err) begin
                strayFlags++;
            end
            prevDone = rx_done;
        end
    end

    function automatic logic goodParity(input logic [7:0] d);
        return (^d) ^ PAR_ODD;
    endfunction

    task automatic clear_queues();
        obsData.delete(); obsFerr.delete(); obsPerr.delete();
        obsBusy.delete(); obsTime.delete();
        expData.delete(); expFerr.delete(); expPerr.delete();
        strayFlags = 0;
    endtask

    // Drives one whole frame and records what the receiver ought to report for it.
    task automatic send_frame(input logic [7:0] d, input logic stopBit, input logic parBit);
        rx = 1'b0;
        repeat (BITP) @(negedge PCLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BITP) @(negedge PCLK);
        end
`ifdef UART_RX_PARITY_EN
        rx = parBit;
        repeat (BITP) @(negedge PCLK);
        expPerr.push_back(((^d) ^ parBit) != PAR_ODD);
`else
        expPerr.push_back(1'b0 & parBit);
`endif
        rx = stopBit;
        repeat (BITP) @(negedge PCLK);
        expData.push_back(d);
        expFerr.push_back(!stopBit);
        lastData = d;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        rx = 1'b1;
        repeat (5) @(negedge PCLK);
        compared++; if (rx_dout !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_dout: got %h, expected 00", rx_dout); end
        compared++; if (rx_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b, expected 0", rx_done); end
        compared++; if (rx_frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ferr: got %b, expected 0", rx_frame_err); end
        compared++; if (rx_parity_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_perr: got %b, expected 0", rx_parity_err); end
        compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b, expected 0", rx_busy); end
        PRESETn = 1'b1;
        repeat (10) @(negedge PCLK);
        compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_busy: got %b, expected 0", rx_busy); end
        lastData = 8'h00;
    endtask

    task automatic test_single_frame();
        clear_queues();
        send_frame(8'hA5, 1'b1, goodParity(8'hA5));
        rx = 1'b1;
        repeat (100) @(negedge PCLK);
        compared++;
        if (obsData.size() !== expData.size()) begin
            mismatched++; $display("[TB] FAIL single_count: got %0d pulses, expected %0d", obsData.size(), expData.size());
        end else begin
            for (int i = 0; i < expData.size(); i++) begin
                compared++;
                if (obsData[i] !== expData[i] || obsFerr[i] !== expFerr[i] || obsPerr[i] !== expPerr[i]) begin
                    mismatched++;
                    $display("[TB] FAIL single_frame[%0d]: got %h/%b/%b, expected %h/%b/%b", i, obsData[i], obsFerr[i], obsPerr[i], expData[i], expFerr[i], expPerr[i]);
                end
            end
            compared++;
            if (obsBusy[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL single_busy_fall: got %b, expected 0", obsBusy[0]); end
        end
        compared++; if (strayFlags !== 0) begin mismatched++; $display("[TB] FAIL single_stray: got %0d, expected 0", strayFlags); end
    endtask

    task automatic test_glitch();
        clear_queues();
        rx = 1'b0;
        repeat (20) @(negedge PCLK);
        rx = 1'b1;
        repeat (60) @(negedge PCLK);
        compared++; if (obsData.size() !== 0) begin mismatched++; $display("[TB] FAIL glitch_pulse: got %0d pulses, expected 0", obsData.size()); end
        compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL glitch_idle: got busy=%b, expected 0", rx_busy); end
        compared++; if (rx_dout !== lastData) begin mismatched++; $display("[TB] FAIL glitch_dout: got %h, expected %h", rx_dout, lastData); end
        send_frame(8'h3C, 1'b1, goodParity(8'h3C));
        rx = 1'b1;
        repeat (100) @(negedge PCLK);
        compared++;
        if (obsData.size() !== expData.size()) begin
            mismatched++; $display("[TB] FAIL glitch_after_count: got %0d pulses, expected %0d", obsData.size(), expData.size());
        end else begin
            for (int i = 0; i < expData.size(); i++) begin
                compared++;
                if (obsData[i] !== expData[i] || obsFerr[i] !== expFerr[i] || obsPerr[i] !== expPerr[i]) begin
                    mismatched++;
                    $display("[TB] FAIL glitch_after[%0d]: got %h/%b/%b, expected %h/%b/%b", i, obsData[i], obsFerr[i], obsPerr[i], expData[i], expFerr[i], expPerr[i]);
                end
            end
        end
    endtask

    task automatic test_frame_error_break();
        clear_queues();
        send_frame(8'h81, 1'b0, goodParity(8'h81));
        rx = 1'b0;
        repeat (3 * FRAME_BITS * BITP) @(negedge PCLK);
        compared++; if (obsData.size() !== 1) begin mismatched++; $display("[TB] FAIL break_single_pulse: got %0d pulses, expected 1", obsData.size()); end
        compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL break_busy: got %b, expected 0", rx_busy); end
        rx = 1'b1;
        repeat (BITP) @(negedge PCLK);
        send_frame(8'h55, 1'b1, goodParity(8'h55));
        rx = 1'b1;
        repeat (100) @(negedge PCLK);
        compared++;
        if (obsData.size() !== expData.size()) begin
            mismatched++; $display("[TB] FAIL break_count: got %0d pulses, expected %0d", obsData.size(), expData.size());
        end else begin
            for (int i = 0; i < expData.size(); i++) begin
                compared++;
                if (obsData[i] !== expData[i] || obsFerr[i] !== expFerr[i] || obsPerr[i] !== expPerr[i]) begin
                    mismatched++;
                    $display("[TB] FAIL break_frame[%0d]: got %h/%b/%b, expected %h/%b/%b", i, obsData[i], obsFerr[i], obsPerr[i], expData[i], expFerr[i], expPerr[i]);
                end
            end
        end
        compared++; if (strayFlags !== 0) begin mismatched++; $display("[TB] FAIL break_stray: got %0d, expected 0", strayFlags); end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        send_frame(8'h00, 1'b1, goodParity(8'h00));
        send_frame(8'hFF, 1'b1, goodParity(8'hFF));
        rx = 1'b1;
        repeat (100) @(negedge PCLK);
        compared++;
        if (obsData.size() !== expData.size()) begin
            mismatched++; $display("[TB] FAIL b2b_count: got %0d pulses, expected %0d", obsData.size(), expData.size());
        end else begin
            for (int i = 0; i < expData.size(); i++) begin
                compared++;
                if (obsData[i] !== expData[i] || obsFerr[i] !== expFerr[i] || obsPerr[i] !== expPerr[i]) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_frame[%0d]: got %h/%b/%b, expected %h/%b/%b", i, obsData[i], obsFerr[i], obsPerr[i], expData[i], expFerr[i], expPerr[i]);
                end
            end
            compared++;
            if (obsTime[1] - obsTime[0] !== FRAME_BITS * BITP) begin
                mismatched++; $display("[TB] FAIL b2b_spacing: got %0d cycles, expected %0d", obsTime[1] - obsTime[0], FRAME_BITS * BITP);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        clear_queues();
        d = 8'h96;
        rx = 1'b0;
        repeat (BITP) @(negedge PCLK);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (BITP) @(negedge PCLK);
        end
        PRESETn = 1'b0;
        #1;
        compared++; if (rx_dout !== 8'h00) begin mismatched++; $display("[TB] FAIL midreset_dout: got %h, expected 00", rx_dout); end
        compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_busy: got %b, expected 0", rx_busy); end
        compared++; if (rx_done !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_done: got %b, expected 0", rx_done); end
        rx = 1'b1;
        repeat (10) @(negedge PCLK);
        PRESETn = 1'b1;
        lastData = 8'h00;
        repeat (BITP) @(negedge PCLK);
        compared++; if (obsData.size() !== 0) begin mismatched++; $display("[TB] FAIL midreset_pulse: got %0d pulses, expected 0", obsData.size()); end
        send_frame(d, 1'b1, goodParity(d));
        rx = 1'b1;
        repeat (100) @(negedge PCLK);
        compared++;
        if (obsData.size() !== expData.size()) begin
            mismatched++; $display("[TB] FAIL midreset_count: got %0d pulses, expected %0d", obsData.size(), expData.size());
        end else begin
            for (int i = 0; i < expData.size(); i++) begin
                compared++;
                if (obsData[i] !== expData[i] || obsFerr[i] !== expFerr[i] || obsPerr[i] !== expPerr[i]) begin
                    mismatched++;
                    $display("[TB] FAIL midreset_frame[%0d]: got %h/%b/%b, expected %h/%b/%b", i, obsData[i], obsFerr[i], obsPerr[i], expData[i], expFerr[i], expPerr[i]);
                end
            end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_queues();
        send_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (100) @(negedge PCLK);
        compared++;
        if (obsData.size() !== expData.size()) begin
            mismatched++; $display("[TB] FAIL parity_count: got %0d pulses, expected %0d", obsData.size(), expData.size());
        end else begin
            for (int i = 0; i < expData.size(); i++) begin
                compared++;
                if (obsData[i] !== expData[i] || obsFerr[i] !== expFerr[i] || obsPerr[i] !== expPerr[i]) begin
                    mismatched++;
                    $display("[TB] FAIL parity_frame[%0d]: got %h/%b/%b, expected %h/%b/%b", i, obsData[i], obsFerr[i], obsPerr[i], expData[i], expFerr[i], expPerr[i]);
                end
            end
        end
        compared++; if (strayFlags !== 0) begin mismatched++; $display("[TB] FAIL parity_stray: got %0d, expected 0", strayFlags); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] d;
        logic       stopBit;
        logic       parBit;
        int         gap;
        clear_queues();
        for (int n = 0; n < 16; n++) begin
            d       = 8'($urandom);
            stopBit = ($urandom_range(0, 4) != 0);
            parBit  = 1'($urandom);
            gap     = stopBit ? $urandom_range(0, 60) : $urandom_range(8, 60);
            send_frame(d, stopBit, parBit);
            rx = 1'b1;
            repeat (gap) @(negedge PCLK);
        end
        rx = 1'b1;
        repeat (100) @(negedge PCLK);
        compared++;
        if (obsData.size() !== expData.size()) begin
            mismatched++; $display("[TB] FAIL random_count: got %0d pulses, expected %0d", obsData.size(), expData.size());
        end else begin
            for (int i = 0; i < expData.size(); i++) begin
                compared++;
                if (obsData[i] !== expData[i] || obsFerr[i] !== expFerr[i] || obsPerr[i] !== expPerr[i]) begin
                    mismatched++;
                    $display("[TB] FAIL random_frame[%0d]: got %h/%b/%b, expected %h/%b/%b", i, obsData[i], obsFerr[i], obsPerr[i], expData[i], expFerr[i], expPerr[i]);
                end
            end
        end
        compared++; if (strayFlags !== 0) begin mismatched++; $display("[TB] FAIL random_stray: got %0d, expected 0", strayFlags); end
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        compared   = 0;
        mismatched = 0;
        strayFlags = 0;
        lastData   = 8'h00;
        PRESETn    = 1'b0;
        rx         = 1'b1;
        @(negedge PCLK);
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error_break();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
